// File: rtl/pisa_pkg.sv
// Shared PISA display definitions: RGB payload, display geometry and pipeline depth.
package pisa_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned PIPE_LAT = 3;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic rgb_t gray_to_rgb(input logic [7:0] v);
    rgb_t p;
    p.r = v;
    p.g = v;
    p.b = v;
    return p;
  endfunction

endpackage

// File: rtl/vga_pixel_fetch_sync2.sv
// Two-flop synchronizer for asynchronous board inputs.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/vga_pixel_fetch.sv
// Grayscale frame-buffer fetch feeding the VGA output block; 3-cycle aligned pipeline.
// Optional 2x2 pixel replication when PIXFETCH_SCALE2_EN is defined.
module vga_pixel_fetch
  import pisa_pkg::*;
#(
  parameter int unsigned IMG_W  = 256,
  parameter int unsigned IMG_H  = 256,
  parameter int unsigned X0     = 192,
  parameter int unsigned Y0     = 112,
  parameter int unsigned ADDR_W = 17,
  parameter logic [23:0] BORDER = 24'h000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              active,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              switch,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic              hsync,
  output logic              vsync,
  output logic              blank_b,
  output logic              cur_buf,
  output logic              frame_start
);

`ifdef PIXFETCH_SCALE2_EN
  localparam int unsigned SCALE = 2;
`else
  localparam int unsigned SCALE = 1;
`endif
  localparam int unsigned WIN_W  = IMG_W * SCALE;
  localparam int unsigned WIN_H  = IMG_H * SCALE;
  localparam int unsigned BUF_SZ = IMG_W * IMG_H;
  // One extra bit so row_base can rest at the end of buffer 1.
  localparam int unsigned RB_W   = ADDR_W + 1;

  logic              sw_sync;
  logic              sel;
  logic              armed;
  logic [RB_W-1:0]   row_base;
  logic [ADDR_W-1:0] col;

  logic              frame0;
  logic              in_win;
  logic              last_col;
  logic              col_step;
  logic              row_step;
  logic [RB_W-1:0]   base_eff;
  logic [ADDR_W-1:0] col_eff;

  logic win1, act1, hs1, vs1, fs1, buf1;
  logic win2, act2, hs2, vs2, fs2, buf2;
  rgb_t pix;

  sync2 u_sync2 (
    .clk   (clk),
    .reset (reset),
    .d     (switch),
    .q     (sw_sync)
  );

  // Window decode; armed blocks a partial frame after reset from reading stale addresses.
  always_comb begin
    frame0   = (x == 10'd0) && (y == 10'd0);
    in_win   = active && (armed || frame0)
               && (32'(x) >= X0) && (32'(x) < X0 + WIN_W)
               && (32'(y) >= Y0) && (32'(y) < Y0 + WIN_H);
    last_col = (32'(x) == X0 + WIN_W - 1);
    col_step = ((32'(x) - X0) % SCALE) == SCALE - 1;
    row_step = ((32'(y) - Y0) % SCALE) == SCALE - 1;
    base_eff = frame0 ? (sw_sync ? RB_W'(BUF_SZ) : '0) : row_base;
    col_eff  = frame0 ? '0 : col;
  end

  // S1: buffer select, row/column walk and address register; frame start overrides row wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel      <= 1'b0;
      armed    <= 1'b0;
      row_base <= '0;
      col      <= '0;
      mem_addr <= '0;
    end else begin
      if (frame0) begin
        sel      <= sw_sync;
        armed    <= 1'b1;
        row_base <= base_eff;
        col      <= '0;
      end
      if (in_win) begin
        mem_addr <= ADDR_W'(base_eff + RB_W'(col_eff));
        if (last_col && !frame0) begin
          col <= '0;
          if (row_step) row_base <= row_base + RB_W'(IMG_W);
        end else if (col_step) begin
          col <= col_eff + ADDR_W'(1);
        end
      end
    end
  end

  // S1/S2 side-band delay so syncs and flags stay aligned with RAM data.
  always_ff @(posedge clk) begin
    if (reset) begin
      win1 <= 1'b0; act1 <= 1'b0; hs1 <= 1'b1; vs1 <= 1'b1; fs1 <= 1'b0; buf1 <= 1'b0;
      win2 <= 1'b0; act2 <= 1'b0; hs2 <= 1'b1; vs2 <= 1'b1; fs2 <= 1'b0; buf2 <= 1'b0;
    end else begin
      win1 <= in_win;
      act1 <= active;
      hs1  <= hsync_in;
      vs1  <= vsync_in;
      fs1  <= frame0;
      buf1 <= frame0 ? sw_sync : sel;
      win2 <= win1;
      act2 <= act1;
      hs2  <= hs1;
      vs2  <= vs1;
      fs2  <= fs1;
      buf2 <= buf1;
    end
  end

  always_comb begin
    pix = '0;
    if (act2) pix = win2 ? gray_to_rgb(mem_rdata) : rgb_t'(BORDER);
  end

  // S3: output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      red         <= 8'd0;
      green       <= 8'd0;
      blue        <= 8'd0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      blank_b     <= 1'b0;
      cur_buf     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      red         <= pix.r;
      green       <= pix.g;
      blue        <= pix.b;
      hsync       <= hs2;
      vsync       <= vs2;
      blank_b     <= act2;
      cur_buf     <= buf2;
      frame_start <= fs2;
    end
  end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Bench for vga_pixel_fetch on a reduced raster; works with or without PIXFETCH_SCALE2_EN.
module tb_vga_pixel_fetch;

  localparam int IMG_W  = 8;
  localparam int IMG_H  = 6;
  localparam int X0     = 5;
  localparam int Y0     = 3;
  localparam int ADDR_W = 7;
  localparam logic [23:0] BORDER = 24'h203040;
`ifdef PIXFETCH_SCALE2_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif
  localparam int H_TOT = 40;
  localparam int V_TOT = 20;
  localparam int H_ACT = 32;
  localparam int V_ACT = 16;
  localparam int NVEC  = 13;

  logic              clk = 1'b0;
  logic              reset;
  logic [9:0]        x, y;
  logic              active, hsync_in, vsync_in, sw;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic [7:0]        red, green, blue;
  logic              hsync, vsync, blank_b, cur_buf, frame_start;

  vga_pixel_fetch #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .X0(X0), .Y0(Y0), .ADDR_W(ADDR_W), .BORDER(BORDER)
  ) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .active(active),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .switch(sw),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .red(red), .green(green), .blue(blue),
    .hsync(hsync), .vsync(vsync), .blank_b(blank_b),
    .cur_buf(cur_buf), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Image RAM: content equals low address byte, one-cycle registered read.
  always @(posedge clk) mem_rdata <= 8'(mem_addr);

  typedef struct {
    int          f, vx, vy;
    logic [31:0] addr;
    logic [23:0] rgb;
    logic        bl, cb, ca;
  } vec_t;

  typedef struct {
    logic [23:0] rgb;
    logic        hs, vs, bl, cb, fs;
    int          tag;
  } exp_t;

  vec_t tbl [NVEC];
  int   hits [NVEC];
  exp_t q[$];
  bit   sw_hist [0:19999];

  int checks = 0, errors = 0;
  int cyc = 0, hx, hy, frame;
  bit armed = 0, sel = 0;
  logic [ADDR_W-1:0] exp_addr = '0;
  bit have_addr = 0;
  int addr_tag = -1;

  function automatic vec_t mk(int f, int vx, int vy, int a, logic [23:0] c,
                              logic bl, logic cb, logic ca);
    vec_t v;
    v.f = f; v.vx = vx; v.vy = vy; v.addr = 32'(a); v.rgb = c;
    v.bl = bl; v.cb = cb; v.ca = ca;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d frame=%0d got=%h want=%h", name, cyc, frame, act, want);
    end
  endtask

  // One clock: check what the last edge produced, then drive the next raster position.
  task automatic step(input logic rst_v, input logic sw_v);
    exp_t e;
    bit   act, win, fs0;
    int   a;
    int   tag;
    @(posedge clk);
    #1;
    if (q.size() == 3) begin
      e = q.pop_front();
      chk("rgb", 32'({red, green, blue}), 32'(e.rgb));
      chk("hsync", 32'(hsync), 32'(e.hs));
      chk("vsync", 32'(vsync), 32'(e.vs));
      chk("blank_b", 32'(blank_b), 32'(e.bl));
      chk("cur_buf", 32'(cur_buf), 32'(e.cb));
      chk("frame_start", 32'(frame_start), 32'(e.fs));
      if (e.tag >= 0) begin
        hits[e.tag]++;
        chk("vec_rgb", 32'({red, green, blue}), 32'(tbl[e.tag].rgb));
        chk("vec_blank", 32'(blank_b), 32'(tbl[e.tag].bl));
        chk("vec_cur_buf", 32'(cur_buf), 32'(tbl[e.tag].cb));
      end
    end
    if (have_addr) begin
      chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
      if (addr_tag >= 0 && tbl[addr_tag].ca)
        chk("vec_addr", 32'(mem_addr), tbl[addr_tag].addr);
    end

    act      = (hx < H_ACT) && (hy < V_ACT);
    reset    = rst_v;
    sw       = sw_v;
    x        = 10'(hx);
    y        = 10'(hy);
    active   = act;
    hsync_in = !(hx >= 34 && hx < 37);
    vsync_in = !(hy >= 17 && hy < 19);
    sw_hist[cyc] = sw_v;

    tag = -1;
    for (int i = 0; i < NVEC; i++)
      if (!rst_v && tbl[i].f == frame && tbl[i].vx == hx && tbl[i].vy == hy) tag = i;

    have_addr = 1;
    addr_tag  = tag;
    if (rst_v) begin
      armed = 0;
      sel = 0;
      exp_addr = '0;
      sw_hist[cyc] = 0;
      if (cyc > 0) sw_hist[cyc-1] = 0;
      q.delete();
      for (int i = 0; i < 3; i++) begin
        e.rgb = '0; e.hs = 1; e.vs = 1; e.bl = 0; e.cb = 0; e.fs = 0; e.tag = -1;
        q.push_back(e);
      end
    end else begin
      fs0 = (hx == 0) && (hy == 0);
      if (fs0) begin
        armed = 1;
        sel = (cyc >= 2) ? sw_hist[cyc-2] : 1'b0;
      end
      win = act && armed && hx >= X0 && hx < X0 + IMG_W*S && hy >= Y0 && hy < Y0 + IMG_H*S;
      a = int'(sel) * IMG_W * IMG_H + ((hy - Y0) / S) * IMG_W + (hx - X0) / S;
      if (win) exp_addr = ADDR_W'(a);
      e.rgb = !act ? 24'h0 : (win ? {3{8'(a)}} : BORDER);
      e.hs = hsync_in; e.vs = vsync_in; e.bl = act; e.cb = sel; e.fs = fs0; e.tag = tag;
      q.push_back(e);
    end

    cyc++;
    hx++;
    if (hx == H_TOT) begin
      hx = 0;
      hy++;
      if (hy == V_TOT) begin
        hy = 0;
        frame++;
      end
    end
  endtask

  initial begin
    logic rst_v, sw_v;
    tbl[0]  = mk(0, 5, 3, 0, 24'h000000, 1, 0, 1);
    tbl[5]  = mk(0, 35, 5, 0, 24'h000000, 0, 0, 0);
    tbl[6]  = mk(1, 5, 3, 48, 24'h303030, 1, 1, 1);
    tbl[8]  = mk(2, 8, 5, 0, BORDER, 1, 0, 1);
    tbl[9]  = mk(3, 5, 3, 0, 24'h000000, 1, 0, 1);
    tbl[10] = mk(6, 5, 3, 48, 24'h303030, 1, 1, 1);
    tbl[11] = mk(7, 5, 3, 48, 24'h303030, 1, 1, 1);
    tbl[12] = mk(8, 5, 3, 0, 24'h000000, 1, 0, 1);
`ifdef PIXFETCH_SCALE2_EN
    tbl[1]  = mk(0, 7, 3, 1, 24'h010101, 1, 0, 1);
    tbl[2]  = mk(0, 5, 5, 8, 24'h080808, 1, 0, 1);
    tbl[3]  = mk(0, 20, 14, 47, 24'h2f2f2f, 1, 0, 1);
    tbl[4]  = mk(0, 21, 14, 47, BORDER, 1, 0, 1);
    tbl[7]  = mk(1, 20, 14, 95, 24'h5f5f5f, 1, 1, 1);
`else
    tbl[1]  = mk(0, 6, 3, 1, 24'h010101, 1, 0, 1);
    tbl[2]  = mk(0, 5, 4, 8, 24'h080808, 1, 0, 1);
    tbl[3]  = mk(0, 12, 8, 47, 24'h2f2f2f, 1, 0, 1);
    tbl[4]  = mk(0, 13, 8, 47, BORDER, 1, 0, 1);
    tbl[7]  = mk(1, 12, 8, 95, 24'h5f5f5f, 1, 1, 1);
`endif
    for (int i = 0; i < NVEC; i++) hits[i] = 0;

    reset = 1; sw = 0; x = '0; y = '0; active = 0; hsync_in = 1; vsync_in = 1;
    hx = 37; hy = V_TOT - 1; frame = -1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);

    sw_v = 1'b0;
    while (frame < 9) begin
      rst_v = 1'b0;
      if (frame == 0 && hx == 10 && hy == 6) sw_v = 1'b1;
      if (frame == 2 && hx == 7 && hy == 5) begin
        rst_v = 1'b1;
        sw_v = 1'b0;
      end
      if ((frame == 3 || frame == 4) && !(frame == 3 && hy == 0 && hx < 20))
        if ($urandom_range(0, 149) == 0) sw_v = ~sw_v;
      if (frame == 5 && hx == 1 && hy == 0) sw_v = 1'b0;
      if (frame == 5 && hx == 38 && hy == V_TOT - 1) sw_v = 1'b1;
      if (frame == 6 && hx == 39 && hy == V_TOT - 1) sw_v = 1'b0;
      step(rst_v, sw_v);
    end
    for (int i = 0; i < 4; i++) step(1'b0, sw_v);

    for (int i = 0; i < NVEC; i++) chk("vec_visited", 32'(hits[i]), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
